// File: rtl/npc_pc_unit.sv
// Registered fetch-PC unit: branch/jump/link/exception redirect with a circular
// return-address stack that predicts RET targets and flags mispredictions.
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic [2:0]                         npc_op,
  input  logic                               zero,
  input  logic [15:0]                        imm16,
  input  logic [25:0]                        imm26,
  input  logic [31:0]                        rs_data,
  input  logic                               exc_req,
  output logic [29:0]                        pc,
  output logic [31:0]                        link_addr,
  output logic [29:0]                        epc,
  output logic                               in_exc,
  output logic                               ras_miss,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_NML  = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_J    = 3'b011,
    OP_JAL  = 3'b100,
    OP_JR   = 3'b101,
    OP_RET  = 3'b110,
    OP_ERET = 3'b111
  } npc_op_e;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_EXC = 1'b1
  } mode_e;

  npc_op_e     op;
  mode_e       mode;
  mode_e       mode_next;
  logic [29:0] p1;
  logic [29:0] br_target;
  logic [29:0] pc_next;
  logic        advance;
  logic        do_push;
  logic        do_pop;
  logic        epc_load;

  logic [29:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic [29:0] ras_top_val;
  logic        ret_miss;

  assign op        = npc_op_e'(npc_op);
  assign p1        = pc + 30'd1;
  assign br_target = p1 + {{14{imm16[15]}}, imm16};
  assign link_addr = {p1, 2'b00};

  // Only an un-stalled, non-excepting cycle executes npc_op and touches the RAS.
  assign advance = !exc_req && !stall;
  assign do_push = advance && (op == OP_JAL);
  assign do_pop  = advance && (op == OP_RET);

  always_comb begin
    pc_next = p1;
    case (op)
      OP_NML:  pc_next = p1;
      OP_BEQ:  pc_next = zero ? br_target : p1;
      OP_BNE:  pc_next = zero ? p1 : br_target;
      OP_J:    pc_next = {pc[29:26], imm26};
      OP_JAL:  pc_next = {pc[29:26], imm26};
      OP_JR:   pc_next = rs_data[31:2];
      OP_RET:  pc_next = rs_data[31:2];
      OP_ERET: pc_next = epc;
    endcase
    if (exc_req) begin
      pc_next = EXC_VEC[31:2];
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC[31:2];
    end else begin
      pc <= pc_next;
    end
  end

  // Exception mode tracking: state register, next-state logic, outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= MODE_RUN;
    end else begin
      mode <= mode_next;
    end
  end

  always_comb begin
    mode_next = mode;
    if (exc_req) begin
      mode_next = MODE_EXC;
    end else if (!stall && (op == OP_ERET)) begin
      mode_next = MODE_RUN;
    end
  end

  always_comb begin
    in_exc   = (mode == MODE_EXC);
    epc_load = exc_req && (mode == MODE_RUN);
  end

  // A nested exception redirects but must not overwrite the original return point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epc <= '0;
    end else if (epc_load) begin
      epc <= pc;
    end
  end

  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CW'(RAS_DEPTH));
  assign ras_top_val = ras_mem[ras_top];
  assign ret_miss    = ras_empty || (ras_top_val != rs_data[31:2]);

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_top + PW'(1)] <= p1;
    end
  end

  // Pushing into a full stack advances the pointer onto the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (do_push) begin
      ras_top <= ras_top + PW'(1);
      if (!ras_full) begin
        ras_count <= ras_count + CW'(1);
      end
    end else if (do_pop && !ras_empty) begin
      ras_top   <= ras_top - PW'(1);
      ras_count <= ras_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_miss <= 1'b0;
    end else begin
      ras_miss <= do_pop && ret_miss;
    end
  end

endmodule

// File: tb/tb_npc_pc_unit.sv
// Randomized scoreboard bench for npc_pc_unit: a stack-based reference model
// predicts every post-edge output, and a separate monitor compares each cycle.
module tb_npc_pc_unit;

  localparam int RAS_DEPTH = 4;
  localparam logic [29:0] RESET_W = 30'h0C00;
  localparam logic [29:0] EXC_W   = 30'h1060;

  localparam logic [2:0] NML = 3'd0, BEQ = 3'd1, BNE = 3'd2, J = 3'd3,
                         JAL = 3'd4, JR = 3'd5, RET = 3'd6, ERET = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n, stall, zero, exc_req;
  logic [2:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [29:0] pc, epc;
  logic [31:0] link_addr;
  logic        in_exc, ras_miss;
  logic [2:0]  ras_count;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] link;
    logic [29:0] epc;
    logic        in_exc;
    logic        miss;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [29:0] m_pc = RESET_W;
  logic [29:0] m_epc = '0;
  logic        m_in_exc = 1'b0;
  logic        m_miss = 1'b0;
  logic [29:0] m_ras[$];

  npc_pc_unit #(.RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .npc_op(npc_op), .zero(zero),
    .imm16(imm16), .imm26(imm26), .rs_data(rs_data), .exc_req(exc_req),
    .pc(pc), .link_addr(link_addr), .epc(epc), .in_exc(in_exc),
    .ras_miss(ras_miss), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model past that edge.
  task automatic apply_stimulus(input logic rst, input logic exc, input logic stl,
                                input logic [2:0] op, input logic z, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] rs);
    exp_t        e;
    logic [29:0] p1;
    logic [29:0] top;
    @(negedge clk);
    rst_n = rst; exc_req = exc; stall = stl; npc_op = op;
    zero = z; imm16 = i16; imm26 = i26; rs_data = rs;
    p1 = m_pc + 30'd1;
    if (!rst) begin
      m_pc = RESET_W; m_epc = '0; m_in_exc = 1'b0; m_miss = 1'b0;
      m_ras.delete();
    end else if (exc) begin
      if (!m_in_exc) begin
        m_epc = m_pc;
        m_in_exc = 1'b1;
      end
      m_pc = EXC_W;
      m_miss = 1'b0;
    end else if (stl) begin
      m_miss = 1'b0;
    end else begin
      m_miss = 1'b0;
      case (op)
        NML:  m_pc = p1;
        BEQ:  m_pc = z ? p1 + 30'(signed'(i16)) : p1;
        BNE:  m_pc = z ? p1 : p1 + 30'(signed'(i16));
        J:    m_pc = {m_pc[29:26], i26};
        JAL: begin
          m_ras.push_back(p1);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
          m_pc = {m_pc[29:26], i26};
        end
        JR:   m_pc = rs[31:2];
        RET: begin
          if (m_ras.size() == 0) begin
            m_miss = 1'b1;
          end else begin
            top = m_ras.pop_back();
            m_miss = (top != rs[31:2]);
          end
          m_pc = rs[31:2];
        end
        default: begin
          m_pc = m_epc;
          m_in_exc = 1'b0;
        end
      endcase
    end
    e.pc = m_pc; e.link = {m_pc + 30'd1, 2'b00}; e.epc = m_epc;
    e.in_exc = m_in_exc; e.miss = m_miss; e.cnt = 3'(m_ras.size());
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [2:0] op, input logic [25:0] i26, input logic [31:0] rs);
    apply_stimulus(1'b1, 1'b0, 1'b0, op, 1'b0, 16'h0, i26, rs);
  endtask

  task automatic settle;
    @(posedge clk);
    #3;
  endtask

  // Monitor: every cycle the DUT presents a new state; compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("pc", 32'(pc), 32'(e.pc));
        check_output("link_addr", link_addr, e.link);
        check_output("epc", 32'(epc), 32'(e.epc));
        check_output("in_exc", 32'(in_exc), 32'(e.in_exc));
        check_output("ras_miss", 32'(ras_miss), 32'(e.miss));
        check_output("ras_count", 32'(ras_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] rs;
    logic [2:0]  op;
    rst_n = 1'b0; stall = 1'b0; exc_req = 1'b0; npc_op = NML;
    zero = 1'b0; imm16 = '0; imm26 = '0; rs_data = '0;

    // Reset, release, sequential fetch.
    apply_stimulus(1'b0, 1'b0, 1'b0, NML, 1'b0, 16'h0, 26'h0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, NML, 1'b0, 16'h0, 26'h0, 32'h0);
    settle();
    check_output("t1_reset_pc", 32'(pc), 32'h0C00);
    step(NML, 26'h0, 32'h0);
    settle();
    check_output("t1_pc", 32'(pc), 32'h0C01);
    check_output("t1_link", link_addr, 32'h0000_3008);

    // Branches with negative offset and J.
    step(JR, 26'h0, 32'h0000_3040);
    apply_stimulus(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    settle();
    check_output("t2_beq", 32'(pc), 32'h0C0F);
    step(JR, 26'h0, 32'h0000_3040);
    apply_stimulus(1'b1, 1'b0, 1'b0, BNE, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    settle();
    check_output("t2_bne", 32'(pc), 32'h0C11);
    step(JR, 26'h0, 32'h0000_3040);
    step(J, 26'h000_0040, 32'h0);
    settle();
    check_output("t2_j", 32'(pc), 32'h0040);

    // JAL/RET hit, then RET on empty stack.
    step(JR, 26'h0, 32'h0000_3080);
    step(JAL, 26'h100, 32'h0);
    settle();
    check_output("t3_count", 32'(ras_count), 32'd1);
    step(RET, 26'h0, 32'h0000_3084);
    settle();
    check_output("t3_ret_pc", 32'(pc), 32'h0C21);
    check_output("t3_hit", 32'(ras_miss), 32'd0);
    step(RET, 26'h0, 32'h0000_3084);
    settle();
    check_output("t3_empty_miss", 32'(ras_miss), 32'd1);
    check_output("t3_empty_count", 32'(ras_count), 32'd0);

    // Overflow: five pushes into a four-entry stack drop the oldest.
    step(JR, 26'h0, 32'h0000_3000);
    step(JAL, 26'h0D00, 32'h0);
    step(JAL, 26'h0E00, 32'h0);
    step(JAL, 26'h0F00, 32'h0);
    step(JAL, 26'h1000, 32'h0);
    step(JAL, 26'h2000, 32'h0);
    settle();
    check_output("t4_full", 32'(ras_count), 32'd4);
    step(RET, 26'h0, 32'h0000_4004);
    step(RET, 26'h0, 32'h0000_3C04);
    step(RET, 26'h0, 32'h0000_3804);
    step(RET, 26'h0, 32'h0000_3404);
    settle();
    check_output("t4_last_hit", 32'(ras_miss), 32'd0);
    step(RET, 26'h0, 32'h0000_3004);
    settle();
    check_output("t4_underflow", 32'(ras_miss), 32'd1);

    // Exception beats stall; nested exception keeps epc; ERET returns.
    step(JR, 26'h0, 32'h0000_3100);
    apply_stimulus(1'b1, 1'b1, 1'b1, NML, 1'b0, 16'h0, 26'h0, 32'h0);
    settle();
    check_output("t5_vec", 32'(pc), 32'h1060);
    check_output("t5_epc", 32'(epc), 32'h0C40);
    check_output("t5_in_exc", 32'(in_exc), 32'd1);
    step(NML, 26'h0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, NML, 1'b0, 16'h0, 26'h0, 32'h0);
    settle();
    check_output("t5_nested_epc", 32'(epc), 32'h0C40);
    step(ERET, 26'h0, 32'h0);
    settle();
    check_output("t5_eret_pc", 32'(pc), 32'h0C40);
    check_output("t5_eret_exc", 32'(in_exc), 32'd0);

    // Reset wins over a simultaneous exception.
    step(JAL, 26'h0500, 32'h0);
    step(JAL, 26'h0600, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, JAL, 1'b0, 16'h0, 26'h0, 32'h0);
    settle();
    check_output("t6_pc", 32'(pc), 32'h0C00);
    check_output("t6_count", 32'(ras_count), 32'd0);
    check_output("t6_in_exc", 32'(in_exc), 32'd0);

    // Randomized phase; RET targets often taken from the model's stack top.
    for (int i = 0; i < 2000; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom();
      if (op == RET && m_ras.size() > 0 && $urandom_range(0, 3) != 0)
        rs = {m_ras[m_ras.size() - 1], 2'($urandom_range(0, 3))};
      apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 7) == 0), op, 1'($urandom_range(0, 1)),
                     16'($urandom()), 26'($urandom()), rs);
    end

    repeat (3) @(posedge clk);
    #4;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
